// File: rtl/multi_bank_fifo_pkg.sv
// multi_bank_fifo_pkg
//   Shared definitions for the multi-bank FIFO: the per-bank state encoding
//   and the width helper used for the full_banks counter.
package multi_bank_fifo_pkg;

  typedef logic [1:0] bank_state_t;

  // FREE: writable. FULL: committed, not yet touched by the reader.
  // DRAIN: the reader has presented at least one word from the bank.
  localparam bank_state_t BANK_FREE  = 2'd0;
  localparam bank_state_t BANK_FULL  = 2'd1;
  localparam bank_state_t BANK_DRAIN = 2'd2;

  // The counter has to hold the value B itself, hence the extra bit.
  function automatic int count_width(input int banks);
    return $clog2(banks) + 1;
  endfunction

endpackage

// File: rtl/multi_bank_fifo_bank_ram.sv
// bank_ram
//   Simple dual-port RAM holding every bank back to back, addressed as
//   {bank, word}. One synchronous write port and one synchronous read port.
//   Ports:
//     clk    - clock, both ports on the rising edge
//     we     - write enable, waddr/wdata captured on the edge
//     re     - read enable; rdata is updated only when set, otherwise holds
//     raddr  - read address
//     rdata  - registered read data
module bank_ram #(
  parameter int W  = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;

  // Storage array: no reset, the FIFO control decides what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads so the presented word stays
  // stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/multi_bank_fifo.sv
// multi_bank_fifo
//   FIFO organised as B banks of 2^N words. The writer fills one bank at a
//   time and commits it when full or on w_flush; the reader drains committed
//   banks in order, one word per cycle, flagging the last word of each bank.
//   Ports:
//     clk, rst              - clock and asynchronous active-high reset
//     w_trigger/w_data      - write offer, accepted when w_ready
//     w_flush               - commit the partially filled write bank
//     w_ready               - the current write bank is FREE
//     r_trigger             - consume the presented word
//     r_data/r_ready/r_last - head word, its valid flag, end-of-bank flag
//     full_banks            - committed banks not yet fully drained
module multi_bank_fifo
  import multi_bank_fifo_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8,
  parameter int B = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_trigger,
  input  logic [W-1:0]              w_data,
  input  logic                      w_flush,
  output logic                      w_ready,
  input  logic                      r_trigger,
  output logic [W-1:0]              r_data,
  output logic                      r_ready,
  output logic                      r_last,
  output logic [count_width(B)-1:0] full_banks
);

  localparam int BW = $clog2(B);
  localparam int AW = BW + N;
  localparam int CW = count_width(B);

  logic [BW-1:0] wbank_q, wbank_d;
  logic [BW-1:0] rbank_q, rbank_d;
  logic [N-1:0]  waddr_q, waddr_d;
  logic [N-1:0]  raddr_q, raddr_d;
  bank_state_t   bank_state_q [B];
  bank_state_t   bank_state_d [B];
  logic [N:0]    bank_len_q [B];
  logic [N:0]    bank_len_d [B];
  logic [B-1:0]  avail_q, avail_d;
  logic [CW-1:0] full_banks_q, full_banks_d;
  logic          run_q, run_d;
  logic          r_ready_q, r_ready_d;
  logic          r_last_q, r_last_d;

  logic          w_accept;
  logic          commit;
  logic [N:0]    commit_len;
  logic          consume;
  logic          start;
  logic          next_word;
  logic          fetch;
  logic          last_consume;
  logic [W-1:0]  ram_rdata;

  // run_q keeps w_ready low during reset and for the edge that ends it.
  assign w_ready = run_q && (bank_state_q[wbank_q] == BANK_FREE);

  // Write side: accept, commit on a full bank or a flush with content, and
  // advance the write bank. Read side: a bank is started only once avail_q
  // has seen it committed for a full cycle, which gives the prefetch cycle
  // after a fresh commit while a bank committed earlier starts straight away.
  always_comb begin
    w_accept   = w_trigger && w_ready;
    commit     = (w_accept && (waddr_q == '1)) ||
                 (w_flush && (w_accept || (waddr_q != '0)));
    commit_len = w_accept ? ({1'b0, waddr_q} + (N+1)'(1)) : {1'b0, waddr_q};

    consume      = r_ready_q && r_trigger;
    last_consume = consume && r_last_q;
    next_word    = consume && !r_last_q;
    start        = !r_ready_q && (bank_state_q[rbank_q] == BANK_FULL) &&
                   avail_q[rbank_q];
    fetch        = start || next_word;

    for (int i = 0; i < B; i++) begin
      bank_state_d[i] = bank_state_q[i];
      bank_len_d[i]   = bank_len_q[i];
      avail_d[i]      = (bank_state_q[i] != BANK_FREE);
    end

    wbank_d   = wbank_q;
    waddr_d   = waddr_q;
    rbank_d   = rbank_q;
    raddr_d   = raddr_q;
    r_ready_d = r_ready_q;
    r_last_d  = r_last_q;
    run_d     = 1'b1;

    if (commit) begin
      bank_state_d[wbank_q] = BANK_FULL;
      bank_len_d[wbank_q]   = commit_len;
      wbank_d               = wbank_q + BW'(1);
      waddr_d               = '0;
    end else if (w_accept) begin
      waddr_d = waddr_q + N'(1);
    end

    if (start) begin
      bank_state_d[rbank_q] = BANK_DRAIN;
    end

    if (fetch) begin
      r_ready_d = 1'b1;
      r_last_d  = (({1'b0, raddr_q} + (N+1)'(1)) == bank_len_q[rbank_q]);
      raddr_d   = raddr_q + N'(1);
    end else if (last_consume) begin
      bank_state_d[rbank_q] = BANK_FREE;
      rbank_d               = rbank_q + BW'(1);
      raddr_d               = '0;
      r_ready_d             = 1'b0;
      r_last_d              = 1'b0;
    end

    full_banks_d = full_banks_q + CW'(commit) - CW'(last_consume);
  end

  // State registers; reset discards every bank and pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q      <= '0;
      rbank_q      <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      avail_q      <= '0;
      full_banks_q <= '0;
      run_q        <= 1'b0;
      r_ready_q    <= 1'b0;
      r_last_q     <= 1'b0;
      for (int i = 0; i < B; i++) begin
        bank_state_q[i] <= BANK_FREE;
        bank_len_q[i]   <= '0;
      end
    end else begin
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      avail_q      <= avail_d;
      full_banks_q <= full_banks_d;
      run_q        <= run_d;
      r_ready_q    <= r_ready_d;
      r_last_q     <= r_last_d;
      bank_state_q <= bank_state_d;
      bank_len_q   <= bank_len_d;
    end
  end

  bank_ram #(
    .W  (W),
    .AW (AW)
  ) u_bank_ram (
    .clk   (clk),
    .we    (w_accept),
    .waddr ({wbank_q, waddr_q}),
    .wdata (w_data),
    .re    (fetch),
    .raddr ({rbank_q, raddr_q}),
    .rdata (ram_rdata)
  );

  // The RAM register may still hold pre-reset contents; masking with
  // r_ready keeps them off the output until a fresh word is fetched.
  assign r_data     = r_ready_q ? ram_rdata : '0;
  assign r_ready    = r_ready_q;
  assign r_last     = r_last_q;
  assign full_banks = full_banks_q;

endmodule

// File: tb/tb_multi_bank_fifo.sv
// tb_multi_bank_fifo
//   Bench for multi_bank_fifo. Instance a (N=3, B=2) runs a vector table and
//   directed sequences; instance b (N=2, B=4) runs a random stream against a
//   queue scoreboard.
module tb_multi_bank_fifo;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         a_w_trigger = 1'b0;
  logic [W-1:0] a_w_data    = '0;
  logic         a_w_flush   = 1'b0;
  logic         a_r_trigger = 1'b0;
  logic         a_w_ready, a_r_ready, a_r_last;
  logic [W-1:0] a_r_data;
  logic [1:0]   a_full_banks;

  logic         b_w_trigger = 1'b0;
  logic [W-1:0] b_w_data    = '0;
  logic         b_w_flush   = 1'b0;
  logic         b_r_trigger = 1'b0;
  logic         b_w_ready, b_r_ready, b_r_last;
  logic [W-1:0] b_r_data;
  logic [2:0]   b_full_banks;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         wt;
    logic [W-1:0] wd;
    logic         fl;
    logic         rt;
    logic         ewr;
    logic         err;
    logic [W-1:0] erd;
    logic         erl;
    logic [1:0]   efb;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int           rand_reads = 0;

  always #5 clk = ~clk;

  multi_bank_fifo #(.W(W), .N(3), .B(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .w_trigger  (a_w_trigger),
    .w_data     (a_w_data),
    .w_flush    (a_w_flush),
    .w_ready    (a_w_ready),
    .r_trigger  (a_r_trigger),
    .r_data     (a_r_data),
    .r_ready    (a_r_ready),
    .r_last     (a_r_last),
    .full_banks (a_full_banks)
  );

  multi_bank_fifo #(.W(W), .N(2), .B(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .w_trigger  (b_w_trigger),
    .w_data     (b_w_data),
    .w_flush    (b_w_flush),
    .w_ready    (b_w_ready),
    .r_trigger  (b_r_trigger),
    .r_data     (b_r_data),
    .r_ready    (b_r_ready),
    .r_last     (b_r_last),
    .full_banks (b_full_banks)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void addVec(input logic wt, input logic [W-1:0] wd,
                                 input logic fl, input logic rt,
                                 input logic ewr, input logic err,
                                 input logic [W-1:0] erd, input logic erl,
                                 input logic [1:0] efb);
    vec_t v;
    v.wt = wt; v.wd = wd; v.fl = fl; v.rt = rt;
    v.ewr = ewr; v.err = err; v.erd = erd; v.erl = erl; v.efb = efb;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    a_w_trigger = v.wt;
    a_w_data    = v.wd;
    a_w_flush   = v.fl;
    a_r_trigger = v.rt;
  endtask

  task automatic stepA();
    @(posedge clk);
    #1;
  endtask

  // Drain instance a with r_trigger high, collecting every consumed word.
  task automatic drainCollect(input int budget);
    int n = 0;
    got_q.delete();
    a_w_trigger = 1'b0;
    a_w_flush   = 1'b0;
    a_r_trigger = 1'b1;
    while ((a_r_ready || a_full_banks != 2'd0) && n < budget) begin
      if (a_r_ready) got_q.push_back(a_r_data);
      stepA();
      n++;
    end
    a_r_trigger = 1'b0;
    checkOutput("drain within budget", 32'(n < budget), 32'd1);
  endtask

  task automatic scoreRead();
    logic [W-1:0] exp_word;
    rand_reads++;
    checkOutput("random read has pending write", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp_word = exp_q.pop_front();
      checkOutput($sformatf("random read %0d data", rand_reads), b_r_data, exp_word);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int rd_cycle[$];
    logic [W-1:0] rd_data[$];
    logic rd_last[$];
    int n;

    // Flush-commit vectors: 3 words, flush, prefetch, hold, drain.
    addVec(1, 16'h0011, 0, 0, 1, 0, 16'h0000, 0, 2'd0);
    addVec(1, 16'h0022, 0, 0, 1, 0, 16'h0000, 0, 2'd0);
    addVec(1, 16'h0033, 0, 0, 1, 0, 16'h0000, 0, 2'd0);
    addVec(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 2'd1);
    addVec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 2'd1);
    addVec(0, 16'h0000, 0, 0, 1, 1, 16'h0011, 0, 2'd1);
    addVec(0, 16'h0000, 0, 0, 1, 1, 16'h0011, 0, 2'd1);
    addVec(0, 16'h0000, 0, 1, 1, 1, 16'h0022, 0, 2'd1);
    addVec(0, 16'h0000, 0, 1, 1, 1, 16'h0033, 1, 2'd1);
    addVec(0, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 2'd0);
    addVec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 2'd0);
    // Flush on an empty bank does nothing.
    addVec(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 2'd0);
    addVec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 2'd0);
    addVec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 2'd0);
    // Flush together with the eighth write: one commit of 8 words.
    for (int i = 0; i < 8; i++) begin
      addVec(1, 16'h0100 + 16'(i), (i == 7), 0, 1, 0, 16'h0000, 0,
             (i == 7) ? 2'd1 : 2'd0);
    end
    addVec(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 2'd1);
    addVec(0, 16'h0000, 0, 0, 1, 1, 16'h0100, 0, 2'd1);
    for (int k = 1; k < 8; k++) begin
      addVec(0, 16'h0000, 0, 1, 1, 1, 16'h0100 + 16'(k), (k == 7), 2'd1);
    end
    addVec(0, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      addVec(0, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 2'd0);
    end

    // Reset state.
    #12;
    checkOutput("reset w_ready", a_w_ready, 0);
    checkOutput("reset r_ready", a_r_ready, 0);
    checkOutput("reset r_last", a_r_last, 0);
    checkOutput("reset r_data", a_r_data, 0);
    checkOutput("reset full_banks", a_full_banks, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("w_ready before first edge", a_w_ready, 0);
    stepA();
    checkOutput("w_ready after first edge", a_w_ready, 1);

    // Table.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      stepA();
      checkOutput($sformatf("vec%0d w_ready", i), a_w_ready, vecs[i].ewr);
      checkOutput($sformatf("vec%0d r_ready", i), a_r_ready, vecs[i].err);
      checkOutput($sformatf("vec%0d full_banks", i), a_full_banks, vecs[i].efb);
      if (vecs[i].err) begin
        checkOutput($sformatf("vec%0d r_data", i), a_r_data, vecs[i].erd);
        checkOutput($sformatf("vec%0d r_last", i), a_r_last, vecs[i].erl);
      end
    end

    // Back-to-back stream of 16 words with the reader always consuming.
    for (int cyc = 0; cyc < 40; cyc++) begin
      a_w_trigger = (cyc < 16);
      a_w_data    = 16'(cyc);
      a_w_flush   = 1'b0;
      a_r_trigger = 1'b1;
      if (a_r_ready) begin
        rd_cycle.push_back(cyc);
        rd_data.push_back(a_r_data);
        rd_last.push_back(a_r_last);
      end
      stepA();
    end
    a_w_trigger = 1'b0;
    a_r_trigger = 1'b0;
    checkOutput("stream count", rd_data.size(), 16);
    for (int k = 0; k < rd_data.size() && k < 16; k++) begin
      checkOutput($sformatf("stream data %0d", k), rd_data[k], k);
      checkOutput($sformatf("stream last %0d", k), rd_last[k], (k % 8 == 7));
    end
    if (rd_data.size() >= 9) begin
      checkOutput("stream bank0 gapless", rd_cycle[7] - rd_cycle[0], 7);
      checkOutput("stream bank switch bubble", rd_cycle[8] - rd_cycle[7] - 1, 1);
    end

    // Overflow: 32 writes into 16 words of space, reader idle.
    for (int i = 0; i < 32; i++) begin
      a_w_trigger = 1'b1;
      a_w_data    = 16'(i);
      stepA();
      checkOutput($sformatf("overflow w_ready after word %0d", i), a_w_ready, (i < 15));
    end
    a_w_trigger = 1'b0;
    checkOutput("overflow full_banks", a_full_banks, 2);
    drainCollect(100);
    checkOutput("overflow read count", got_q.size(), 16);
    for (int k = 0; k < got_q.size() && k < 16; k++) begin
      checkOutput($sformatf("overflow read %0d", k), got_q[k], k);
    end

    // Reset in the middle of draining with both banks committed.
    for (int i = 0; i < 16; i++) begin
      a_w_trigger = 1'b1;
      a_w_data    = 16'h1000 + 16'(i);
      stepA();
    end
    a_w_trigger = 1'b0;
    a_r_trigger = 1'b1;
    stepA();
    stepA();
    a_r_trigger = 1'b0;
    checkOutput("pre-reset full_banks", a_full_banks, 2);
    rst = 1'b1;
    #1;
    checkOutput("mid-drain reset r_ready", a_r_ready, 0);
    checkOutput("mid-drain reset full_banks", a_full_banks, 0);
    checkOutput("mid-drain reset w_ready", a_w_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepA();
    checkOutput("w_ready after reset release", a_w_ready, 1);
    a_w_trigger = 1'b1;
    a_w_data    = 16'hA5A5;
    a_w_flush   = 1'b1;
    stepA();
    a_w_trigger = 1'b0;
    a_w_flush   = 1'b0;
    n = 0;
    while (!a_r_ready && n < 8) begin
      stepA();
      n++;
    end
    checkOutput("post-reset edges to r_ready", n, 2);
    checkOutput("post-reset first word", a_r_data, 16'hA5A5);
    checkOutput("post-reset r_last", a_r_last, 1);
    checkOutput("post-reset full_banks", a_full_banks, 1);
    a_r_trigger = 1'b1;
    stepA();
    checkOutput("post-reset drained r_ready", a_r_ready, 0);
    checkOutput("post-reset drained full_banks", a_full_banks, 0);
    repeat (4) stepA();
    a_r_trigger = 1'b0;
    checkOutput("no stale word after reset", a_r_ready, 0);

    // Random traffic on the four-bank instance.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      b_w_trigger = ($urandom_range(0, 99) < 60);
      b_w_data    = 16'($urandom);
      b_w_flush   = ($urandom_range(0, 99) < 8);
      b_r_trigger = ($urandom_range(0, 99) < 55);
      if (b_w_trigger && b_w_ready) exp_q.push_back(b_w_data);
      if (b_r_ready && b_r_trigger) scoreRead();
      stepA();
      checkOutput("random full_banks bound", 32'(b_full_banks <= 3'd4), 32'd1);
    end
    b_w_trigger = 1'b0;
    b_w_flush   = 1'b1;
    b_r_trigger = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (b_r_ready && b_r_trigger) scoreRead();
      stepA();
      b_w_flush = 1'b0;
    end
    b_r_trigger = 1'b0;
    checkOutput("random leftover words", exp_q.size(), 0);
    checkOutput("random final full_banks", b_full_banks, 0);
    checkOutput("random throughput", 32'(rand_reads > 1000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
